// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding and load-op codes for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 76;
  localparam int MEM_TO_WB_WD = 70;
  localparam int STALL_WD     = 6;
  localparam int HILO_WD      = 66;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LW   = 3'b001;
  localparam logic [2:0] LD_LB   = 3'b010;
  localparam logic [2:0] LD_LBU  = 3'b011;
  localparam logic [2:0] LD_LH   = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the addressed byte/half from the SRAM word and extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted_s;
  logic [15:0] half_s;

  // Byte/half lane selection; addr[0] is deliberately ignored for halfwords.
  always_comb begin
    shifted_s = rdata >> {addr, 3'b000};
    if (addr[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension per load type; undefined codes behave as a full-word load.
  always_comb begin
    data = rdata;
    case (ld_op)
      LD_NONE: data = rdata;
      LD_LW:   data = rdata;
      LD_LB:   data = ext8(shifted_s[7:0], 1'b1);
      LD_LBU:  data = ext8(shifted_s[7:0], 1'b0);
      LD_LH:   data = ext16(half_s, 1'b1);
      LD_LHU:  data = ext16(half_s, 1'b0);
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM input register, load data alignment, WB bus and forwarding copies.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [2:0]              ex_ld_op,
  input  logic [HILO_WD-1:0]      hilo_ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [HILO_WD-1:0]      hilo_mem_to_wb_bus,
  output logic                    mem_wreg,
  output logic [4:0]              mem_waddr,
  output logic [31:0]             mem_wdata,
  output logic                    mem_hi_we,
  output logic                    mem_lo_we,
  output logic [31:0]             mem_hi_wdata,
  output logic [31:0]             mem_lo_wdata
);

  logic [EX_TO_MEM_WD-1:0] ex_bus_r;
  logic [2:0]              ld_op_r;
  logic [HILO_WD-1:0]      hilo_r;

  logic [31:0] pc_s;
  logic        sel_rf_res_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic [31:0] ex_result_s;
  logic [31:0] load_data_s;
  logic [31:0] rf_wdata_s;
  logic        unused_s;

  // Input register: load, insert a bubble when only this stage stalls, or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_bus_r <= '0;
      ld_op_r  <= 3'b000;
      hilo_r   <= '0;
    end else if (stall[3] == NO_STOP) begin
      ex_bus_r <= ex_to_mem_bus;
      ld_op_r  <= ex_ld_op;
      hilo_r   <= hilo_ex_to_mem_bus;
    end else if (stall[4] == NO_STOP) begin
      ex_bus_r <= '0;
      ld_op_r  <= 3'b000;
      hilo_r   <= '0;
    end else begin
      ex_bus_r <= ex_bus_r;
      ld_op_r  <= ld_op_r;
      hilo_r   <= hilo_r;
    end
  end

  assign pc_s         = ex_bus_r[75:44];
  assign sel_rf_res_s = ex_bus_r[38];
  assign rf_we_s      = ex_bus_r[37];
  assign rf_waddr_s   = ex_bus_r[36:32];
  assign ex_result_s  = ex_bus_r[31:0];

  // RAM enable/write-enable only matter to the SRAM port driven in EX.
  assign unused_s = ^{stall[5], stall[2:0], ex_bus_r[43:39]};

  mem_load_align u_load_align (
    .ld_op (ld_op_r),
    .addr  (ex_result_s[1:0]),
    .rdata (data_sram_rdata),
    .data  (load_data_s)
  );

  // Writeback data source select.
  always_comb begin
    if (sel_rf_res_s) begin
      rf_wdata_s = load_data_s;
    end else begin
      rf_wdata_s = ex_result_s;
    end
  end

  assign mem_to_wb_bus      = {pc_s, rf_we_s, rf_waddr_s, rf_wdata_s};
  assign hilo_mem_to_wb_bus = hilo_r;

  assign mem_wreg     = rf_we_s;
  assign mem_waddr    = rf_waddr_s;
  assign mem_wdata    = rf_wdata_s;
  assign mem_hi_we    = hilo_r[1];
  assign mem_lo_we    = hilo_r[0];
  assign mem_hi_wdata = hilo_r[65:34];
  assign mem_lo_wdata = hilo_r[33:2];

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state rising-edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-003 SHALL have: stall  input  `StallBus  pipeline stall vector; bit 3 = this stage's input register, bit 4 = downstream.
REQ-004 SHALL have: ex_to_mem_bus  input  `EX_TO_MEM_WD (76)  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-005 SHALL have: ex_ld_op  input  3  load type from EX, captured with ex_to_mem_bus.
REQ-006 SHALL have: hilo_ex_to_mem_bus  input  66  {hi_wdata[65:34], lo_wdata[33:2], hi_we[1], lo_we[0]}.
REQ-007 SHALL have: data_sram_rdata  input  32  synchronous-SRAM read word, valid in the cycle after EX issued the address.
REQ-008 SHALL have: mem_to_wb_bus  output  `MEM_TO_WB_WD (70)  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-009 SHALL have: hilo_mem_to_wb_bus  output  66  registered hilo bus passed through, same layout as input.
REQ-010 SHALL have: mem_wreg 1, mem_waddr 5, mem_wdata 32, mem_hi_we 1, mem_lo_we 1, mem_hi_wdata 32, mem_lo_wdata 32  outputs  forwarding copies of the values driven on the WB buses.

Function
REQ-011 Input register (bus, ld_op, hilo bus) SHALL load on rising clk when stall[3]=NoStop.
REQ-012 When stall[3]=Stop and stall[4]=NoStop, register SHALL load all-zero (bubble: rf_we=0, hi_we=lo_we=0, ld_op=0).
REQ-013 When stall[3]=Stop and stall[4]=Stop, register SHALL hold its value.
REQ-014 Load encodings: 000 none, 001 LW, 010 LB, 011 LBU, 100 LH, 101 LHU; 110/111 SHALL be treated as LW.
REQ-015 Byte select SHALL use registered ex_result[1:0]; LB/LBU take rdata byte [8*a+7:8*a]; LB sign-extends bit 7, LBU zero-extends.
REQ-016 LH/LHU SHALL take rdata[15:0] for addr[1]=0, rdata[31:16] for addr[1]=1; LH sign-extends bit 15, LHU zero-extends; addr[0] ignored (no alignment exception).
REQ-017 rf_wdata SHALL equal aligned load data when sel_rf_res=1, else registered ex_result.
REQ-018 If sel_rf_res=1 with ld_op=000, rf_wdata SHALL be the full rdata word.
REQ-019 pc, rf_we, rf_waddr, hilo fields SHALL pass from the register unchanged; latency EX->WB bus = 1 clk.
REQ-020 Forwarding outputs SHALL be combinational copies of the WB-bus fields in the same cycle (no extra delay).
REQ-021 Stores (data_ram_wen≠0) SHALL produce no register write unless rf_we is set by upstream; block SHALL NOT gate rf_we itself.
REQ-022 During a held register (REQ-013) outputs SHALL stay stable; data_sram_rdata sampling is caller's responsibility (SRAM not re-read).

Reset
REQ-023 On rst=0, asynchronously, all register bits SHALL clear; all outputs consequently read 0 (rf_we=0, hi_we=lo_we=0, pc=0).
REQ-024 Reset mid-stall SHALL override hold/bubble; first load after rst deassertion obeys REQ-011..013.

Structure
REQ-025 `MEM_TO_WB_WD, `EX_TO_MEM_WD, `StallBus, `Stop/`NoStop and the five load-op codes SHALL live in lib/defines.vh.
REQ-026 Load alignment/extension SHALL be one combinational sub-module mem_load_align (ld_op, addr[1:0], rdata -> data).
REQ-027 The input register SHALL be the only state; target 120-200 lines RTL total.

Verification
REQ-028 LB, addr=...03, rdata=0x80FF_1234 -> rf_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-029 LH addr[1]=1, rdata=0x8001_7FFF -> 0xFFFF_8001; LHU addr[1]=0 -> 0x0000_7FFF.
REQ-030 ALU op, sel_rf_res=0, ex_result=0x1234_5678, rf_we=1, waddr=5 -> next cycle mem_wdata=0x1234_5678, mem_waddr=5, mem_wreg=1.
REQ-031 stall[3]=1, stall[4]=0 for one cycle -> rf_we=0, hi_we=lo_we=0 next cycle; stall[3]=stall[4]=1 -> outputs unchanged.
REQ-032 hilo bus hi=0xDEAD_BEEF, lo=1, hi_we=lo_we=1 -> identical on hilo_mem_to_wb_bus and mem_hi_*/mem_lo_* after 1 clk.
REQ-033 Assert rst=0 between clock edges with valid data held -> outputs 0 immediately, before next clk edge.
